// File: rtl/lsm_sequencer_if.sv
// Signal bundle for lsm_sequencer: command inputs, memory port, register-file port, base writeback.
// master = controller/memory/register-file side, slave = the sequencer itself.
interface lsm_sequencer_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTES          = DATA_WIDTH / 8,
  parameter int unsigned LIST_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4
) ();
  logic                      Start;
  logic                      Load;
  logic                      Pre;
  logic                      Up;
  logic                      Wb;
  logic [LIST_WIDTH-1:0]     Reg_list;
  logic [REG_ADDR_WIDTH-1:0] Base_reg;
  logic [DATA_WIDTH-1:0]     Base_addr;
  logic                      Mem_ready;
  logic [DATA_WIDTH-1:0]     Mem_rdata;
  logic [DATA_WIDTH-1:0]     Reg_rdata;

  logic                      Busy;
  logic                      Done;
  logic                      Mem_req;
  logic                      Mem_we;
  logic [DATA_WIDTH-1:0]     Mem_addr;
  logic [DATA_WIDTH-1:0]     Mem_wdata;
  logic [REG_ADDR_WIDTH-1:0] Reg_r_addr;
  logic [REG_ADDR_WIDTH-1:0] Reg_w_addr;
  logic [DATA_WIDTH-1:0]     Reg_wdata;
  logic [BYTES-1:0]          Reg_byte_w_en;
  logic [DATA_WIDTH-1:0]     Base_wdata;
  logic [BYTES-1:0]          Base_byte_w_en;

  modport master (
    output Start, Load, Pre, Up, Wb, Reg_list, Base_reg, Base_addr,
           Mem_ready, Mem_rdata, Reg_rdata,
    input  Busy, Done, Mem_req, Mem_we, Mem_addr, Mem_wdata, Reg_r_addr,
           Reg_w_addr, Reg_wdata, Reg_byte_w_en, Base_wdata, Base_byte_w_en
  );

  modport slave (
    input  Start, Load, Pre, Up, Wb, Reg_list, Base_reg, Base_addr,
           Mem_ready, Mem_rdata, Reg_rdata,
    output Busy, Done, Mem_req, Mem_we, Mem_addr, Mem_wdata, Reg_r_addr,
           Reg_w_addr, Reg_wdata, Reg_byte_w_en, Base_wdata, Base_byte_w_en
  );
endinterface

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: expands a register list into one word transfer per cycle plus base writeback.
// Define LSM_EMPTY_LIST_EN for ARMv4 empty-list behaviour (R15 only, n=16 addressing).
module lsm_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTES          = DATA_WIDTH / 8,
  parameter int unsigned LIST_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4
) (
  input logic            Clk,
  input logic            Rst,
  lsm_sequencer_if.slave bus
);
  localparam int unsigned CNT_WIDTH = $clog2(LIST_WIDTH + 1);
  localparam logic [BYTES-1:0] BEN_ON  = '0;
  localparam logic [BYTES-1:0] BEN_OFF = '1;

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t                    state, state_next;
  logic [LIST_WIDTH-1:0]     rem;
  logic [DATA_WIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0]     base_new;
  logic                      load_q;
  logic                      wb_q;

  logic [LIST_WIDTH-1:0]     list_eff;
  logic [CNT_WIDTH-1:0]      n_eff;
  logic [DATA_WIDTH-1:0]     span;
  logic [DATA_WIDTH-1:0]     first_addr;
  logic [DATA_WIDTH-1:0]     base_calc;
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] cur_reg;
  logic                      last_word;
  logic                      xfer_done;
  logic                      store_xfer;
  logic                      load_xfer;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [LIST_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < LIST_WIDTH; i++) c += CNT_WIDTH'(v[i]);
    return c;
  endfunction

  always_comb begin
    list_eff = bus.Reg_list;
    n_eff    = popcount(bus.Reg_list);
`ifdef LSM_EMPTY_LIST_EN
    if (bus.Reg_list == '0) begin
      list_eff                 = '0;
      list_eff[LIST_WIDTH-1]   = 1'b1;
      n_eff                    = CNT_WIDTH'(LIST_WIDTH);
    end
`endif
    span = DATA_WIDTH'(n_eff) << 2;
    case ({bus.Pre, bus.Up})
      2'b01:   first_addr = bus.Base_addr;
      2'b11:   first_addr = bus.Base_addr + DATA_WIDTH'(4);
      2'b00:   first_addr = bus.Base_addr - span + DATA_WIDTH'(4);
      default: first_addr = bus.Base_addr - span;
    endcase
    base_calc = bus.Up ? bus.Base_addr + span : bus.Base_addr - span;
    // A loaded base register takes the loaded value, so its writeback is dropped.
    wb_en = bus.Wb && (list_eff != '0) && !(bus.Load && list_eff[bus.Base_reg]);
  end

  always_comb begin
    cur_reg = '0;
    for (int unsigned i = LIST_WIDTH; i > 0; i--)
      if (rem[i-1]) cur_reg = REG_ADDR_WIDTH'(i - 1);
  end

  assign last_word  = (rem & (rem - LIST_WIDTH'(1))) == '0;
  assign xfer_done  = (state == XFER) && bus.Mem_ready;
  assign store_xfer = (state == XFER) && !load_q;
  assign load_xfer  = (state == XFER) && load_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      rem      <= '0;
      addr     <= '0;
      base_new <= '0;
      load_q   <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.Start) begin
        rem      <= list_eff;
        addr     <= first_addr;
        base_new <= base_calc;
        load_q   <= bus.Load;
        wb_q     <= wb_en;
      end else if (xfer_done) begin
        rem  <= rem & (rem - LIST_WIDTH'(1));
        addr <= addr + DATA_WIDTH'(4);
      end
    end
  end

  // An empty list still passes through WB (with writes disabled) so Done lands two cycles after Start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Start) state_next = (list_eff != '0) ? XFER : WB;
      XFER:    if (bus.Mem_ready && last_word) state_next = WB;
      WB:      state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy           = state != IDLE;
    bus.Done           = state == DONE;
    bus.Mem_req        = state == XFER;
    bus.Mem_we         = store_xfer;
    bus.Mem_addr       = (state == XFER) ? addr : '0;
    bus.Reg_r_addr     = store_xfer ? cur_reg : '0;
    bus.Mem_wdata      = store_xfer ? bus.Reg_rdata : '0;
    bus.Reg_w_addr     = load_xfer ? cur_reg : '0;
    bus.Reg_wdata      = load_xfer ? bus.Mem_rdata : '0;
    bus.Reg_byte_w_en  = (load_xfer && bus.Mem_ready) ? BEN_ON : BEN_OFF;
    bus.Base_wdata     = (state == WB && wb_q) ? base_new : '0;
    bus.Base_byte_w_en = (state == WB && wb_q) ? BEN_ON : BEN_OFF;
  end
endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: expected transfers queued at Start, popped as words complete.
module tb_lsm_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsm_sequencer_if bus ();
  lsm_sequencer dut (.Clk(clk), .Rst(rst), .bus(bus));

  localparam logic [31:0] RKEY = 32'hA5A5_0000;
  localparam logic [31:0] WTAG = 32'h5000_0000;

  assign bus.Mem_rdata = bus.Mem_addr ^ RKEY;
  assign bus.Reg_rdata = WTAG | 32'(bus.Reg_r_addr);

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rg;
    logic [31:0] data;
  } xfer_t;

  xfer_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic load, input logic pre, input logic up, input logic wb,
                        input logic [3:0] base_reg, input logic [31:0] base,
                        input logic [15:0] list, input int stall_word,
                        input int stall_cycles, input logic poke);
    logic [15:0] lst;
    logic [31:0] lo, exp_base;
    logic [3:0]  exp_ben;
    xfer_t       x;
    int n, k, exp_bw, exp_done, bw, words, stalled, done_cyc;
    lst = list;
    n   = $countones(list);
`ifdef LSM_EMPTY_LIST_EN
    if (list == 16'h0000) begin
      lst = 16'h8000;
      n   = 16;
    end
`endif
    if (up) lo = base + (pre ? 32'd4 : 32'd0);
    else    lo = base - 32'(4 * n) + (pre ? 32'd0 : 32'd4);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        x.addr = lo + 32'(4 * k);
        x.rg   = 4'(i);
        x.data = load ? (x.addr ^ RKEY) : (WTAG | 32'(i));
        q.push_back(x);
        k++;
      end
    end
    exp_bw   = (wb && lst != 16'h0000 && !(load && lst[base_reg])) ? 1 : 0;
    exp_base = up ? base + 32'(4 * n) : base - 32'(4 * n);
    exp_done = (lst == 16'h0000) ? 2 : n + 2 + ((stall_word < n) ? stall_cycles : 0);

    bus.Load = load; bus.Pre = pre; bus.Up = up; bus.Wb = wb;
    bus.Base_reg = base_reg; bus.Base_addr = base; bus.Reg_list = list;
    bus.Mem_ready = 1'b1; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.Load = ~load; bus.Pre = ~pre; bus.Up = ~up; bus.Wb = ~wb;
    bus.Base_reg = 4'($urandom); bus.Base_addr = $urandom; bus.Reg_list = 16'($urandom);

    words = 0; stalled = 0; bw = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      bus.Mem_ready = !(words == stall_word && stalled < stall_cycles);
      if (!bus.Mem_ready) stalled++;
      if (poke) bus.Start = (cyc == 2);
      @(negedge clk);
      check("busy", 32'(bus.Busy), 32'd1);
      check("mem_req", 32'(bus.Mem_req), 32'(q.size() != 0));
      exp_ben = (q.size() != 0 && bus.Mem_ready && load) ? 4'h0 : 4'hF;
      check("reg_byte_w_en", 32'(bus.Reg_byte_w_en), 32'(exp_ben));
      if (q.size() != 0 && bus.Mem_req) begin
        check("mem_addr", bus.Mem_addr, q[0].addr);
        check("mem_we", 32'(bus.Mem_we), 32'(!load));
        if (load) begin
          check("reg_w_addr", 32'(bus.Reg_w_addr), 32'(q[0].rg));
          if (bus.Mem_ready) check("reg_wdata", bus.Reg_wdata, q[0].data);
        end else begin
          check("reg_r_addr", 32'(bus.Reg_r_addr), 32'(q[0].rg));
          check("mem_wdata", bus.Mem_wdata, q[0].data);
        end
        if (bus.Mem_ready) begin
          void'(q.pop_front());
          words++;
        end
      end
      if (bus.Base_byte_w_en != 4'hF) begin
        bw++;
        check("base_byte_w_en", 32'(bus.Base_byte_w_en), 32'h0);
        check("base_wdata", bus.Base_wdata, exp_base);
      end
      if (bus.Done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("base_writes", 32'(bw), 32'(exp_bw));
    check("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    bus.Start = 1'b0;
    bus.Mem_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_done", 32'(bus.Busy), 32'd0);
    check("done_one_cycle", 32'(bus.Done), 32'd0);
  endtask

  task automatic reset_mid_op();
    bus.Load = 1'b0; bus.Pre = 1'b1; bus.Up = 1'b1; bus.Wb = 1'b1;
    bus.Base_reg = 4'd13; bus.Base_addr = 32'h800; bus.Reg_list = 16'h0F00;
    bus.Mem_ready = 1'b1; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    @(posedge clk); #1;
    check("mid_mem_req", 32'(bus.Mem_req), 32'd1);
    check("mid_mem_addr", bus.Mem_addr, 32'h808);
    bus.Reg_list = 16'h0003;
    bus.Start = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_mem_req", 32'(bus.Mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.Mem_we), 32'd0);
    check("rst_mem_addr", bus.Mem_addr, 32'd0);
    check("rst_mem_wdata", bus.Mem_wdata, 32'd0);
    check("rst_reg_ben", 32'(bus.Reg_byte_w_en), 32'hF);
    check("rst_base_ben", 32'(bus.Base_byte_w_en), 32'hF);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_mem_req", 32'(bus.Mem_req), 32'd0);
      check("post_rst_busy", 32'(bus.Busy), 32'd0);
      check("post_rst_base_ben", 32'(bus.Base_byte_w_en), 32'hF);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0; bus.Load = 1'b0; bus.Pre = 1'b0; bus.Up = 1'b0; bus.Wb = 1'b0;
    bus.Reg_list = '0; bus.Base_reg = '0; bus.Base_addr = '0; bus.Mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_mem_req", 32'(bus.Mem_req), 32'd0);
    check("reset_mem_addr", bus.Mem_addr, 32'd0);
    check("reset_reg_ben", 32'(bus.Reg_byte_w_en), 32'hF);
    check("reset_base_ben", 32'(bus.Base_byte_w_en), 32'hF);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_0100, 16'h000F, -1, 0, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h0000_0200, 16'hC001, -1, 0, 1'b1);
    run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 32'h0000_0300, 16'h00F0,  1, 3, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  32'h0000_0400, 16'h0006, -1, 0, 1'b0);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  32'h0000_0004, 16'h0007, -1, 0, 1'b0);
    run_op(1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  32'hFFFF_FFF8, 16'h0101, -1, 0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  32'h0000_0500, 16'h0000, -1, 0, 1'b0);
    reset_mid_op();
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  32'h0000_0900, 16'hA5A5,  0, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
